// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU. Base operations complete in one registered
// cycle; multiply/divide run iteratively, one bit per cycle, into HI/LO.
//
// state | meaning
// IDLE  | ready for a new op; single-cycle ops retire here, mul/div launch
// CALC  | one shift-add or restoring-divide step per cycle, WIDTH cycles
// FIX   | sign correction, HI/LO written, md_done pulses
module alu_muldiv #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] selected_A,
    input  logic [WIDTH-1:0] selected_B,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             out_valid,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_MULT  = 4'd10;
    localparam logic [3:0] OP_MULTU = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_MFHI  = 4'd14;
    localparam logic [3:0] OP_MFLO  = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t state_q, state_d;

    logic               accept, is_md, is_div_op, is_signed_op, div_by_zero;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   sub_res, alu_res;
    logic [SHAMT_W-1:0] shamt;

    logic [SHAMT_W-1:0] cnt_q;
    logic               is_div_q, neg_q, neg_r;
    logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;

    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign accept       = in_valid && in_ready;
    assign is_md        = (ctrl >= OP_MULT) && (ctrl <= OP_DIVU);
    assign is_div_op    = (ctrl == OP_DIV) || (ctrl == OP_DIVU);
    assign is_signed_op = (ctrl == OP_MULT) || (ctrl == OP_DIV);
    assign div_by_zero  = is_div_op && (selected_B == '0);

    assign a_neg = is_signed_op && selected_A[WIDTH-1];
    assign b_neg = is_signed_op && selected_B[WIDTH-1];
    assign a_mag = a_neg ? -selected_A : selected_A;
    assign b_mag = b_neg ? -selected_B : selected_B;

    assign shamt   = selected_A[SHAMT_W-1:0];
    assign sub_res = selected_A - selected_B;

    // Single-cycle result selection.
    always_comb begin
        alu_res = '0;
        case (ctrl)
            OP_ADD:  alu_res = selected_A + selected_B;
            OP_SUB:  alu_res = sub_res;
            OP_AND:  alu_res = selected_A & selected_B;
            OP_OR:   alu_res = selected_A | selected_B;
            OP_XOR:  alu_res = selected_A ^ selected_B;
            OP_NOR:  alu_res = ~(selected_A | selected_B);
            OP_SLT:  alu_res[0] = $signed(selected_A) < $signed(selected_B);
            OP_SLL:  alu_res = selected_B << shamt;
            OP_SRL:  alu_res = selected_B >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(selected_B) >>> shamt);
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // One iteration step: acc_hi is the partial product / partial remainder,
    // acc_lo the multiplier / dividend being shifted out (quotient shifted in).
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -acc_lo : acc_lo;
    assign rem_fix  = neg_r ? -acc_hi : acc_hi;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state; only IDLE can take a new op. Divide by zero skips CALC.
    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == S_IDLE);
        case (state_q)
            S_IDLE:  if (accept && is_md) state_d = div_by_zero ? S_FIX : S_CALC;
            S_CALC:  if (cnt_q == '0) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: single-cycle results, mul/div operand load, iteration, HI/LO write.
    always_ff @(posedge clk) begin
        if (reset) begin
            result    <= '0;
            zero_flag <= 1'b0;
            out_valid <= 1'b0;
            md_done   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
        end else begin
            out_valid <= 1'b0;
            md_done   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept && !is_md) begin
                        result    <= alu_res;
                        zero_flag <= (ctrl == OP_SUB) && (sub_res == '0);
                        out_valid <= 1'b1;
                    end else if (accept) begin
                        cnt_q    <= SHAMT_W'(WIDTH - 1);
                        is_div_q <= is_div_op;
                        if (div_by_zero) begin
                            // Preload the fixed divide-by-zero answer; FIX passes it through.
                            acc_hi <= selected_A;
                            acc_lo <= '1;
                            neg_q  <= 1'b0;
                            neg_r  <= 1'b0;
                        end else if (is_div_op) begin
                            acc_hi <= '0;
                            acc_lo <= a_mag;
                            opnd   <= b_mag;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                        end else begin
                            acc_hi <= '0;
                            acc_lo <= b_mag;
                            opnd   <= a_mag;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (is_div_q) begin
                        acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    md_done <= 1'b1;
                    if (is_div_q) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
